// File: rtl/vr_traffic_gen_pkg.sv
// ---------------------------------------------------------------------------
// vr_pkg : shared types and constants for the valid/ready traffic generator.
//   vr_state_e  - generator FSM states
//   LFSR_W      - width of the gap LFSR
//   LFSR_TAPS   - Galois feedback mask for taps 16,14,13,11 (right-shifting)
// ---------------------------------------------------------------------------
package vr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } vr_state_e;

    localparam int              LFSR_W    = 16;
    // Bits 15,13,12,10 correspond to polynomial taps 16,14,13,11.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/vr_traffic_gen_if.sv
// ---------------------------------------------------------------------------
// vr_traffic_gen_if : valid/ready stream link.
//   valid - source has a word on data
//   ready - sink accepts the word this cycle
//   data  - payload, DATA_W bits
// Modports: master (drives valid/data), slave (drives ready).
// ---------------------------------------------------------------------------
interface vr_traffic_gen_if #(
    parameter int DATA_W = 8
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/vr_traffic_gen_lfsr.sv
// ---------------------------------------------------------------------------
// vr_lfsr : right-shifting Galois LFSR that advances only when step is high.
//   clk   - clock
//   reset - asynchronous, active-low; loads SEED
//   step  - advance one state this cycle
//   value - current LFSR state
// SEED must be non-zero or the register locks up at zero.
// ---------------------------------------------------------------------------
module vr_lfsr
    import vr_pkg::*;
#(
    parameter int               WIDTH = LFSR_W,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            value <= SEED;
        else if (step)
            value <= {1'b0, value[WIDTH-1:1]} ^ ({WIDTH{value[0]}} & TAPS);
    end

endmodule

// File: rtl/vr_traffic_gen.sv
// ---------------------------------------------------------------------------
// vr_traffic_gen : valid/ready stream source for link bring-up and stress.
// Emits num_txn incrementing words starting at data_start, each preceded by
// an idle gap that is either fixed_delay or an LFSR draw in 0..MAX_DELAY.
//   clk, reset   - clock, asynchronous active-low reset
//   start / stop - one-cycle pulses; start a run when idle / end it early
//   rand_en      - 0: fixed gap, 1: random gap
//   fixed_delay  - gap length used when rand_en=0
//   num_txn      - transfers per run, 0 = unlimited (latched on start)
//   data_start   - first data word (latched on start)
//   link         - master side of the valid/ready link
//   busy         - run in progress
//   done         - one-cycle pulse at the end of a run
//   txn_count    - completed transfers in the current/last run
// ---------------------------------------------------------------------------
module vr_traffic_gen
    import vr_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                CNT_W     = 16,
    parameter int                MAX_DELAY = 5,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               rand_en,
    input  logic [3:0]         fixed_delay,
    input  logic [CNT_W-1:0]   num_txn,
    input  logic [DATA_W-1:0]  data_start,
    vr_traffic_gen_if.master   link,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   txn_count
);

    vr_state_e          state, state_n;
    logic [3:0]         dcnt, dcnt_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [DATA_W-1:0]  data_q, data_n;
    logic [CNT_W-1:0]   num_q, num_n;
    logic               pend, pend_n;     // stop seen while holding valid
    logic               step;
    logic [LFSR_W-1:0]  lfsr_val;
    logic [3:0]         rnd_gap;
    logic [3:0]         gap;
    logic               lfsr_unused;

    vr_lfsr #(
        .WIDTH (LFSR_W),
        .SEED  (LFSR_SEED),
        .TAPS  (LFSR_TAPS)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (step),
        .value (lfsr_val)
    );

    // Only the low byte feeds the gap draw.
    assign lfsr_unused = ^lfsr_val[LFSR_W-1:8];
    assign rnd_gap     = 4'(lfsr_val[7:0] % 8'(MAX_DELAY + 1));
    // Config sampled live: whatever rand_en/fixed_delay are at the draw.
    assign gap         = rand_en ? rnd_gap : fixed_delay;

    // Next-state and datapath. Every draw (start or a non-final transfer)
    // pulses step so the LFSR advances exactly once per gap.
    always_comb begin
        state_n = state;
        dcnt_n  = dcnt;
        cnt_n   = cnt;
        data_n  = data_q;
        num_n   = num_q;
        pend_n  = pend;
        step    = 1'b0;
        case (state)
            IDLE: begin
                // stop is deliberately ignored here, even alongside start.
                if (start) begin
                    num_n  = num_txn;
                    cnt_n  = '0;
                    data_n = data_start;
                    pend_n = 1'b0;
                    step   = 1'b1;
                    if (gap == 4'd0) begin
                        state_n = SEND;
                    end else begin
                        state_n = WAIT;
                        dcnt_n  = gap;
                    end
                end
            end
            WAIT: begin
                if (stop) begin
                    state_n = DONE;
                end else begin
                    dcnt_n = dcnt - 4'd1;
                    if (dcnt == 4'd1)
                        state_n = SEND;
                end
            end
            SEND: begin
                if (stop)
                    pend_n = 1'b1;
                if (link.ready) begin
                    cnt_n  = cnt + CNT_W'(1);
                    data_n = data_q + DATA_W'(1);
                    if (((num_q != '0) && (cnt_n == num_q)) || stop || pend) begin
                        state_n = DONE;
                    end else begin
                        step = 1'b1;
                        if (gap != 4'd0) begin
                            state_n = WAIT;
                            dcnt_n  = gap;
                        end
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                pend_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            dcnt   <= '0;
            cnt    <= '0;
            data_q <= '0;
            num_q  <= '0;
            pend   <= 1'b0;
        end else begin
            state  <= state_n;
            dcnt   <= dcnt_n;
            cnt    <= cnt_n;
            data_q <= data_n;
            num_q  <= num_n;
            pend   <= pend_n;
        end
    end

    // All outputs decode registered state, so valid never sees ready.
    assign link.valid = (state == SEND);
    assign link.data  = data_q;
    assign busy       = (state == WAIT) || (state == SEND);
    assign done       = (state == DONE);
    assign txn_count  = cnt;

endmodule

// File: tb/tb_vr_traffic_gen.sv
// ---------------------------------------------------------------------------
// tb_vr_traffic_gen : randomized self-checking bench for vr_traffic_gen.
// A transaction-level model predicts, per run, the idle gap before every
// transfer and the word carried by it; the monitor measures gaps, checks
// valid/data stability under random backpressure and the end-of-run pulse.
// ---------------------------------------------------------------------------
module tb_vr_traffic_gen;

    localparam int          DATA_W    = 8;
    localparam int          CNT_W     = 16;
    localparam int          MAX_DELAY = 5;
    localparam logic [15:0] SEED      = 16'hACE1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              rand_en = 1'b0;
    logic [3:0]        fixed_delay = 4'd0;
    logic [CNT_W-1:0]  num_txn = '0;
    logic [DATA_W-1:0] data_start = '0;
    logic              busy, done;
    logic [CNT_W-1:0]  txn_count;

    vr_traffic_gen_if #(.DATA_W(DATA_W)) vr ();

    vr_traffic_gen #(
        .DATA_W    (DATA_W),
        .CNT_W     (CNT_W),
        .MAX_DELAY (MAX_DELAY),
        .LFSR_SEED (SEED)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .rand_en     (rand_en),
        .fixed_delay (fixed_delay),
        .num_txn     (num_txn),
        .data_start  (data_start),
        .link        (vr),
        .busy        (busy),
        .done        (done),
        .txn_count   (txn_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic [15:0] m_lfsr = SEED;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Polynomial x^16+x^14+x^13+x^11+1, Galois form shifting toward bit 0.
    function automatic int draw(input bit ren, input int fd);
        int d;
        bit out;
        if (ren) d = int'(m_lfsr[7:0]) % (MAX_DELAY + 1);
        else     d = fd;
        out    = m_lfsr[0];
        m_lfsr = m_lfsr >> 1;
        if (out)
            m_lfsr = m_lfsr ^ ((16'h1 << 15) | (16'h1 << 13) | (16'h1 << 12) | (16'h1 << 10));
        return d;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        vr.ready = 1'b0;
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        m_lfsr = SEED;
        @(negedge clk);
    endtask

    // One complete run. pct = ready probability in percent, spam = throw
    // start pulses at the busy generator, ss = stop together with start.
    task automatic do_run(input int n, input logic [7:0] ds, input bit ren,
                          input int fd, input int pct, input bit spam, input bit ss);
        int d, gap, hold;
        bit r;
        logic [7:0] dexp;
        @(negedge clk);
        rand_en     = ren;
        fixed_delay = 4'(fd);
        num_txn     = CNT_W'(n);
        data_start  = ds;
        start       = 1'b1;
        stop        = ss;
        d    = draw(ren, fd);
        dexp = ds;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        for (int k = 0; k < n; k++) begin
            gap = 0;
            while (!vr.valid && gap <= 40) begin
                vr.ready = 1'($urandom_range(1));
                start    = spam ? 1'($urandom_range(1)) : 1'b0;
                @(negedge clk);
                gap++;
            end
            chk("gap", gap, d);
            if (ren) chk("gap_range", (gap <= MAX_DELAY), 1);
            chk("busy_run", busy, 1);
            hold = 0;
            do begin
                chk("valid_hold", vr.valid, 1);
                chk("data", vr.data, dexp);
                r        = ($urandom_range(99) < pct);
                vr.ready = r;
                start    = spam ? 1'($urandom_range(1)) : 1'b0;
                @(negedge clk);
                hold++;
            end while (!r && hold < 200);
            vr.ready = 1'b0;
            start    = 1'b0;
            dexp++;
            chk("txn_count", txn_count, k + 1);
            if (k < n - 1) d = draw(ren, fd);
        end
        chk("done_pulse", done, 1);
        chk("valid_end", vr.valid, 0);
        chk("busy_end", busy, 0);
        @(negedge clk);
        chk("done_1cyc", done, 0);
        chk("cnt_hold", txn_count, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        bit quiet;
        vr.ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", vr.valid, 0);
        chk("rst_data", vr.data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", txn_count, 0);
        reset = 1'b1;
        @(negedge clk);

        do_run(4, 8'h10, 1'b0, 0, 100, 1'b0, 1'b0);   // back-to-back
        do_run(3, 8'h20, 1'b0, 2, 100, 1'b1, 1'b0);   // fixed gap 2, start spam
        do_run(6, 8'h40, 1'b0, 1, 40, 1'b0, 1'b0);    // backpressure
        do_run(3, 8'h50, 1'b0, 0, 100, 1'b0, 1'b1);   // start+stop together

        // Random gaps, repeated from reset: model replays the same LFSR.
        do_reset();
        do_run(50, 8'h00, 1'b1, 0, 100, 1'b0, 1'b0);
        do_reset();
        do_run(50, 8'h00, 1'b1, 0, 100, 1'b0, 1'b0);
        do_run(20, 8'($urandom), 1'b1, 0, 60, 1'b1, 1'b0);

        // stop while waiting out a gap
        @(negedge clk);
        rand_en = 1'b0; fixed_delay = 4'd3; num_txn = 16'd5; data_start = 8'h60;
        start = 1'b1;
        d = draw(1'b0, 3);
        @(negedge clk);
        start = 1'b0;
        chk("wstop_valid0", vr.valid, 0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("wstop_done", done, 1);
        chk("wstop_cnt", txn_count, 0);
        quiet = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (vr.valid || done) quiet = 1'b0;
        end
        chk("wstop_quiet", quiet, 1);

        // stop while holding valid under backpressure
        @(negedge clk);
        fixed_delay = 4'd0; num_txn = 16'd10; data_start = 8'h70; vr.ready = 1'b0;
        start = 1'b1;
        d = draw(1'b0, 0);
        @(negedge clk);
        start = 1'b0;
        chk("sstop_valid", vr.valid, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("sstop_hold1", vr.valid, 1);
        chk("sstop_data1", vr.data, 8'h70);
        @(negedge clk);
        chk("sstop_hold2", vr.valid, 1);
        chk("sstop_data2", vr.data, 8'h70);
        vr.ready = 1'b1;
        @(negedge clk);
        vr.ready = 1'b0;
        chk("sstop_done", done, 1);
        chk("sstop_valid0", vr.valid, 0);
        chk("sstop_cnt", txn_count, 1);
        @(negedge clk);
        chk("sstop_done0", done, 0);

        // unlimited run with data wrap, then async reset mid-transfer
        @(negedge clk);
        fixed_delay = 4'd0; num_txn = 16'd0; data_start = 8'hFE; vr.ready = 1'b1;
        start = 1'b1;
        d = draw(1'b0, 0);
        @(negedge clk);
        start = 1'b0;
        chk("wrap_fe", vr.data, 8'hFE);
        @(negedge clk);
        chk("wrap_ff", vr.data, 8'hFF);
        chk("wrap_cnt1", txn_count, 1);
        @(negedge clk);
        chk("wrap_00", vr.data, 8'h00);
        chk("wrap_valid", vr.valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", vr.valid, 0);
        chk("arst_data", vr.data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_cnt", txn_count, 0);
        vr.ready = 1'b0;
        @(negedge clk);
        reset  = 1'b1;
        m_lfsr = SEED;
        quiet  = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done || vr.valid || busy) quiet = 1'b0;
        end
        chk("arst_quiet", quiet, 1);

        // generator still usable after the abort
        do_run(5, 8'h90, 1'b1, 0, 70, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/vr_traffic_gen.md
Name: vr_traffic_gen

Overview:
Synthesizable, parametrised valid/ready stream source for bring-up and stress testing of valid/ready links. It generates a configurable number of incrementing data words, inserting either a fixed or an LFSR-pseudo-random idle gap before each transfer. It connects as the Master side of a valid/ready link and obeys the valid-stability rule under arbitrary backpressure. It replaces behavioural sources that depend on simulator randomisation, so the same traffic profiles also run on hardware.

Parameters:
DATA_W, 8, data bus width in bits
CNT_W, 16, width of the transaction count and the num_txn port
MAX_DELAY, 5, upper bound of a random gap in cycles; range 0..15
LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a run when idle
stop  in  1  one-cycle pulse; ends the run early
rand_en  in  1  0 = fixed gap, 1 = random gap
fixed_delay  in  4  gap in cycles when rand_en=0
num_txn  in  CNT_W  transfers per run; 0 = unlimited
data_start  in  DATA_W  first data word of the run
valid  out  1  link valid
ready  in  1  link ready
data  out  DATA_W  link data
busy  out  1  high while a run is in progress
done  out  1  one-cycle pulse when a run ends
txn_count  out  CNT_W  completed transfers in the current run

Behaviour:
- Reset (async, active-low): valid=0, data=0, busy=0, done=0, txn_count=0, lfsr=LFSR_SEED, state=IDLE. Asserting reset mid-run aborts immediately. No done pulse.
- Handshake: a transfer occurs on a rising edge with valid&&ready. Once valid rises, valid and data stay stable until that transfer completes. valid never depends combinationally on ready.
- Gap draw: rand_en=0 gives d=fixed_delay. rand_en=1 gives d=lfsr[7:0] % (MAX_DELAY+1). The LFSR advances one step only on each draw: 16-bit Galois, taps 16,14,13,11.
- rand_en and fixed_delay are sampled at each draw. num_txn and data_start are latched on start.
- States: IDLE, WAIT, SEND, DONE.
- IDLE: on start, latch config, set txn_count=0 and data=data_start, set busy=1, then draw d. If d==0 go to SEND; else go to WAIT with dcnt=d.
- WAIT: valid=0. Decrement dcnt each cycle. When dcnt==1, go to SEND. This gives exactly d cycles of valid=0, after which valid goes high.
- SEND: valid=1. On a transfer: txn_count++, data++ (mod 2^DATA_W).
  - If num_txn!=0 and the new count equals num_txn, or stop was seen, go to DONE.
  - Otherwise draw a new d. If d==0, stay in SEND with valid still high (one transfer per cycle). Else go to WAIT.
- DONE: valid=0, done=1 for one cycle, busy=0, then IDLE. txn_count holds until the next start.
- stop in WAIT: go to DONE next cycle.
- stop in SEND: latch a pending-stop flag. valid stays high until the handshake, then go to DONE. The run is never truncated mid-transfer.
- stop in IDLE: ignored. start while busy: ignored. start and stop in the same IDLE cycle: start wins, and stop is ignored.
- Unlimited run (num_txn=0): txn_count wraps 2^CNT_W-1 → 0 and the run continues.

Decomposition:
- Package vr_pkg: state enum (IDLE/WAIT/SEND/DONE), LFSR width and tap constant.
- Sub-module vr_lfsr: parameters WIDTH and SEED; ports clk, reset, step, value.

Test Plan:
- Fixed gap, back-to-back: fixed_delay=0, num_txn=4, data_start=8'h10, ready=1 → valid high in the cycle after start for 4 consecutive cycles; data 10,11,12,13; done pulses the following cycle; txn_count=4.
- Fixed gap of 2: fixed_delay=2, num_txn=3, ready=1 → valid pattern 0,0,1,0,0,1,0,0,1 after start; done after the third transfer.
- Backpressure: ready=0 for 3 cycles while valid=1 → valid and data stable through all 3 cycles; exactly one transfer when ready=1.
- Random gap: rand_en=1, MAX_DELAY=5, num_txn=50, ready=1 → every gap in 0..5; a repeated run after reset yields an identical gap sequence.
- Stop: stop during WAIT → done with no further valid. stop during SEND with ready=0 for 2 cycles → valid held, one transfer, then done.
- Wrap and reset: num_txn=0, data_start=8'hFE → data FE, FF, 00. Assert reset while valid=1 → all outputs return to reset values asynchronously, with no done pulse.
